// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Build option LOCK_LOSS_CNT_EN (in the top) adds a saturating lock-loss counter output.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_seq_state_t;

   localparam int LOCK_LOSS_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchroniser with synchronous active-high reset to a selectable value.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Build option LOCK_LOSS_CNT_EN adds output lock_loss_cnt (saturating count of RUN lock losses).
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int  PLL_RST_CYCLES = 16,
   parameter int  LOCK_TIMEOUT   = 50000,
   parameter int  LOCK_STABLE    = 1024,
   parameter int  MAX_RETRIES    = 3,
   localparam int RETRY_W        = $clog2(MAX_RETRIES + 1)
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               restart,
   input  logic               locked,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
`ifdef LOCK_LOSS_CNT_EN
   output logic [LOCK_LOSS_W-1:0] lock_loss_cnt,
`endif
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK->STABLE edge already samples one locked cycle, so STABLE ends one count early.
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

   pll_seq_state_t     state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [RETRY_W-1:0] retry_inc_s;
   logic               locked_s;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;

   sync2 #(
      .RESET_VAL (1'b0)
   ) u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   assign retry_inc_s = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_ONE;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      if (restart) begin
         state_d = PLL_RESET;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            PLL_RESET: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  cnt_d = '0;
                  if (LOCK_STABLE > 1) begin
                     state_d = STABLE;
                  end else begin
                     state_d = RUN;
                     retry_d = '0;
                  end
               end else if (cnt_q == TO_LAST) begin
                  cnt_d   = '0;
                  retry_d = retry_inc_s;
                  if (retry_inc_s == RETRY_MAX) begin
                     state_d = FAIL;
                  end else begin
                     state_d = PLL_RESET;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STB_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            RUN: begin
               cnt_d   = '0;
               retry_d = '0;
               if (!locked_s) begin
                  state_d = PLL_RESET;
               end else begin
                  state_d = RUN;
               end
            end
            FAIL: begin
               state_d = FAIL;
               cnt_d   = '0;
            end
            default: begin
               state_d = PLL_RESET;
               cnt_d   = '0;
               retry_d = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the very edge that enters a state.
   always_comb begin
      pll_rst_d = (state_d == PLL_RESET) || (state_d == FAIL);
      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fail_d    = (state_d == FAIL);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= PLL_RESET;
         cnt_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

`ifdef LOCK_LOSS_CNT_EN
   logic [LOCK_LOSS_W-1:0] loss_q, loss_d;
   logic                   loss_evt_s;

   // A lock loss that coincides with restart is a commanded re-sequence, not a loss.
   always_comb begin
      loss_evt_s = (state_q == RUN) && !locked_s && !restart;
      if (loss_evt_s && (loss_q != {LOCK_LOSS_W{1'b1}})) begin
         loss_d = loss_q + LOCK_LOSS_W'(1);
      end else begin
         loss_d = loss_q;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer (small timing parameters).
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LTO = 100;
   localparam int LST = 16;
   localparam int MR  = 3;

   logic       refclk  = 1'b0;
   logic       rst     = 1'b1;
   logic       restart = 1'b0;
   logic       locked  = 1'b0;
   logic       pll_rst, sys_rst, ready, fail;
   logic [1:0] retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   pll_reset_sequencer #(
      .PLL_RST_CYCLES (PRC),
      .LOCK_TIMEOUT   (LTO),
      .LOCK_STABLE    (LST),
      .MAX_RETRIES    (MR)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .restart       (restart),
      .locked        (locked),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .fail          (fail),
`ifdef LOCK_LOSS_CNT_EN
      .lock_loss_cnt (lock_loss_cnt),
`endif
      .retry_cnt     (retry_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      vectors++;
      assert (sb_q.size() != 0) else begin
         miscompares++;
         $error("FAIL sb_empty observed=%0d expected=<queued entry>", obs);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
         end
      end
   endtask

   function automatic logic out_bit(input int sel);
      case (sel)
         0:       return pll_rst;
         1:       return sys_rst;
         2:       return ready;
         default: return fail;
      endcase
   endfunction

   // Edges until output sel equals val; -1 if the budget runs out.
   task automatic wait_bit(input int sel, input logic val, input int budget, output int cyc);
      cyc = 0;
      while (out_bit(sel) !== val && cyc < budget) begin
         tick(1);
         cyc++;
      end
      if (out_bit(sel) !== val) cyc = -1;
   endtask

   task automatic wait_retry(input logic [1:0] val, input int budget, output int cyc);
      cyc = 0;
      while (retry_cnt !== val && cyc < budget) begin
         tick(1);
         cyc++;
      end
      if (retry_cnt !== val) cyc = -1;
   endtask

   task automatic check_reset_vals(input string tag);
      push({tag, "_pll_rst"}, 1); check(pll_rst);
      push({tag, "_sys_rst"}, 1); check(sys_rst);
      push({tag, "_ready"},   0); check(ready);
      push({tag, "_fail"},    0); check(fail);
      push({tag, "_retry"},   0); check(retry_cnt);
   endtask

   initial begin
      int cyc;

      // 1: reset, PLL reset pulse length, lock to release latency
      tick(1);
      check_reset_vals("rst");
`ifdef LOCK_LOSS_CNT_EN
      push("rst_loss", 0); check(lock_loss_cnt);
`endif
      rst = 1'b0;
      push("pll_rst_len", PRC); wait_bit(0, 1'b0, 50, cyc); check(cyc);
      tick(10);
      locked = 1'b1;
      push("lock_to_ready", 2 + LST); wait_bit(2, 1'b1, 200, cyc); check(cyc);
      push("run_sys_rst", 0); check(sys_rst);
      push("run_retry", 0);   check(retry_cnt);

      // 3: lock loss in RUN, automatic re-lock
      locked = 1'b0;
      push("loss_to_sys_rst", 3); wait_bit(1, 1'b1, 20, cyc); check(cyc);
      push("loss_ready", 0);      check(ready);
      push("loss_pll_rst", 1);    check(pll_rst);
      locked = 1'b1;
      push("relock_to_ready", PRC + 1 + LST - 1); wait_bit(2, 1'b1, 200, cyc); check(cyc);
`ifdef LOCK_LOSS_CNT_EN
      push("loss_cnt_1", 1); check(lock_loss_cnt);
`endif

      // 4: glitch during STABLE forces a fresh stable window
      restart = 1'b1; tick(1); restart = 1'b0;
      push("rs_ready", 0);   check(ready);
      push("rs_sys_rst", 1); check(sys_rst);
      push("rs_pll_rst", 1); check(pll_rst);
      tick(13);
      locked = 1'b0;
      tick(3);
      push("glitch_ready", 0);   check(ready);
      push("glitch_sys_rst", 1); check(sys_rst);
      push("glitch_pll_rst", 0); check(pll_rst);
      push("glitch_retry", 0);   check(retry_cnt);
      locked = 1'b1;
      push("glitch_to_ready", 2 + LST); wait_bit(2, 1'b1, 200, cyc); check(cyc);
`ifdef LOCK_LOSS_CNT_EN
      push("restart_no_loss", 1); check(lock_loss_cnt);
`endif

      // 5: restart coinciding with synchronised lock loss in RUN
      locked = 1'b0;
      tick(2);
      restart = 1'b1; tick(1); restart = 1'b0;
      push("rsl_pll_rst", 1); check(pll_rst);
      push("rsl_sys_rst", 1); check(sys_rst);
      push("rsl_ready", 0);   check(ready);
      push("rsl_retry", 0);   check(retry_cnt);
`ifdef LOCK_LOSS_CNT_EN
      push("rsl_loss", 1); check(lock_loss_cnt);
`endif

      // 2: lock never arrives -> three timed-out attempts then FAIL
      push("retry1_time", PRC + LTO); wait_retry(2'd1, 400, cyc); check(cyc);
      push("retry1_pll_rst", 1);      check(pll_rst);
      push("retry1_fail", 0);         check(fail);
      push("retry2_time", PRC + LTO); wait_retry(2'd2, 400, cyc); check(cyc);
      push("retry3_time", PRC + LTO); wait_retry(2'd3, 400, cyc); check(cyc);
      push("fail_fail", 1);    check(fail);
      push("fail_pll_rst", 1); check(pll_rst);
      push("fail_sys_rst", 1); check(sys_rst);
      push("fail_ready", 0);   check(ready);
      tick(20);
      push("fail_hold", 1);       check(fail);
      push("fail_retry_hold", 3); check(retry_cnt);
      restart = 1'b1; tick(1); restart = 1'b0;
      push("unfail_fail", 0);    check(fail);
      push("unfail_retry", 0);   check(retry_cnt);
      push("unfail_pll_rst", 1); check(pll_rst);
      push("unfail_pll_len", PRC); wait_bit(0, 1'b0, 50, cyc); check(cyc);

      // 6: rst in WAIT_LOCK with retry_cnt=2
      push("retry2_again", 2 * LTO + PRC); wait_retry(2'd2, 600, cyc); check(cyc);
      tick(PRC + 6);
      push("wl_pll_rst", 0); check(pll_rst);
      push("wl_retry", 2);   check(retry_cnt);
      rst = 1'b1; tick(1); rst = 1'b0;
      check_reset_vals("midrst");
`ifdef LOCK_LOSS_CNT_EN
      push("midrst_loss", 0); check(lock_loss_cnt);
      locked = 1'b1;
      push("sat_first_ready", 1); wait_bit(2, 1'b1, 200, cyc); check(ready);
      for (int i = 0; i < 300; i++) begin
         locked = 1'b0;
         wait_bit(1, 1'b1, 20, cyc);
         locked = 1'b1;
         wait_bit(2, 1'b1, 200, cyc);
         if (i == 99) begin
            push("loss_cnt_100", 100); check(lock_loss_cnt);
         end
      end
      push("loss_cnt_sat", 255); check(lock_loss_cnt);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
